// File: rtl/freq_meter_pkg.sv
// Shared frequency-meter constants: range select codes,
// gate lengths in timebase ticks and gate FSM state codes.
package freq_meter_pkg;

  localparam logic [1:0] SEL_100K = 2'b00;
  localparam logic [1:0] SEL_10K  = 2'b01;
  localparam logic [1:0] SEL_1K   = 2'b11;

  localparam logic [6:0] GT_100K = 7'd1;
  localparam logic [6:0] GT_10K  = 7'd10;
  localparam logic [6:0] GT_1K   = 7'd100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 2'b10 is unused and falls back to the 10-tick gate
  function automatic logic [6:0] gate_ticks(
    input logic [1:0] sel
  );
    logic [6:0] n;
    unique case (sel)
      SEL_100K: n = GT_100K;
      SEL_1K:   n = GT_1K;
      default:  n = GT_10K;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of a ripple counter.
// Ports: clk, clear (sync reset), clr, inc, q, q_nxt, carry.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       clear,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic [3:0] q_nxt,
  output logic       carry
);

  assign carry = inc & (q == 4'd9);

  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = 4'd0;
    else if (inc)
      q_nxt = (q == 4'd9) ? 4'd0 : q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (clear)
      q <= 4'd0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated BCD pulse counter: counts sig_in rising edges over a
// 1/10/100-tick gate (std_f_sel), latches dout, flags cntover/cntlow.
// Ports: clk, clear (sync reset), reset (restart), std_f_sel,
// sig_in, cntover, cntlow, dout, dvalid.
// FREQ_SIG_SYNC_EN adds a 2-flop synchronizer on sig_in.
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int TB_DIV = 100000,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                reset,
  input  logic [1:0]          std_f_sel,
  input  logic                sig_in,
  output logic                cntover,
  output logic                cntlow,
  output logic [4*DIGITS-1:0] dout,
  output logic                dvalid
);

  localparam int PW = $clog2(TB_DIV);
  localparam int CW = 4 * DIGITS;
  localparam logic [PW-1:0] P_LAST = PW'(TB_DIV - 1);
  localparam logic [CW-1:0] ALL9 = {DIGITS{4'h9}};

  logic [1:0]        state;
  logic [PW-1:0]     presc;
  logic [6:0]        ticks;
  logic [6:0]        gate_n;
  logic              sig_s;
  logic              cur;
  logic              prev;
  logic              rise;
  logic              inc;
  logic              ovf;
  logic              tick;
  logic              gate_end;
  logic              clr;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] is9;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic              unused_carry;

`ifdef FREQ_SIG_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (clear)
      sync <= 2'b00;
    else
      sync <= {sync[0], sig_in};
  end

  assign sig_s = sync[1];
`else
  assign sig_s = sig_in;
`endif

  assign rise = cur & ~prev;
  assign inc  = (state == GATE) & ~reset & rise;
  assign ovf  = inc & (&is9);

  // Saturate at all 9s: the final edge is not fed into the chain
  assign chain[0] = inc & ~ovf;
  assign clr      = reset | (state == IDLE);

  assign tick     = (presc == P_LAST);
  assign gate_end = tick && (ticks == gate_n - 7'd1);

  // Top carry can never fire because the chain is saturated
  assign unused_carry = chain[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_cnt u_dig (
      .clk   (clk),
      .clear (clear),
      .clr   (clr),
      .inc   (chain[i]),
      .q     (cnt_q[4*i +: 4]),
      .q_nxt (cnt_nxt[4*i +: 4]),
      .carry (chain[i+1])
    );
    assign is9[i] = (cnt_q[4*i +: 4] == 4'd9);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      presc   <= '0;
      ticks   <= '0;
      gate_n  <= '0;
      cntover <= 1'b0;
      cntlow  <= 1'b0;
      dvalid  <= 1'b0;
      dout    <= '0;
      cur     <= 1'b0;
      prev    <= 1'b0;
    end else begin
      cur  <= sig_s;
      prev <= cur;
      if (reset) begin
        state   <= IDLE;
        presc   <= '0;
        ticks   <= '0;
        cntover <= 1'b0;
        cntlow  <= 1'b0;
        dvalid  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= GATE;
            gate_n <= gate_ticks(std_f_sel);
            presc  <= '0;
            ticks  <= '0;
          end
          GATE: begin
            if (ovf) begin
              state   <= DONE;
              cntover <= 1'b1;
              cntlow  <= 1'b0;
              dout    <= ALL9;
              dvalid  <= 1'b1;
            end else if (gate_end) begin
              state   <= DONE;
              cntover <= 1'b0;
              cntlow  <= (cnt_nxt[CW-1 -: 4] == 4'd0);
              dout    <= cnt_nxt;
              dvalid  <= 1'b1;
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              if (tick)
                ticks <= ticks + 7'd1;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
